piso_feeder: RTL and testbench
==============================

# piso_feeder

Buffers N-bit codewords from the Reed-Solomon encoder output and launches them one at a time into the downstream parallel-to-serial serializer. Accepts words on a valid/ready handshake into a DEPTH-entry FIFO. Issues a one-cycle load strobe to the serializer, then waits for its one-cycle completion pulse before launching the next word, so no codeword is overwritten mid-transmission.

## Interface
- `N`, 7, codeword width in bits; must match the serializer.
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `TIMEOUT`, 16, cycles in WAIT before timeout fires; used only with the macro, ≥N+2.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  N  codeword from encoder.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept; `!full`; forced 0 while `rst_n` low.
- `ser_data`  out  N  word to serializer `data_in`; registered.
- `ser_valid`  out  1  one-cycle load strobe to serializer `data_valid`.
- `ser_done`  in  1  serializer completion pulse (`done`).
- `busy`  out  1  high in WAIT.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `err_timeout`  out  1  sticky timeout flag; tied 0 without the macro.

## Operation
- Reset values:
  - `ser_data`=0, `ser_valid`=0, `busy`=0, `count`=0, `err_timeout`=0.
  - FIFO pointers are 0; FSM is in IDLE.
- FIFO write: on `in_valid && in_ready`, store `in_data` at the write pointer and advance it.
  - Pointers wrap modulo DEPTH.
- `in_ready` = `count != DEPTH`.
  - A write is refused when the FIFO is full, even in the cycle a pop occurs.
- Simultaneous push and pop: `count` is unchanged, and both pointers advance.
- FSM states:
  - IDLE: if `count>0`, pop the head word, register it into `ser_data`, assert `ser_valid` for exactly one cycle, and go to WAIT. Otherwise stay. `ser_done` is ignored in IDLE.
  - WAIT: `busy`=1 and `ser_data` is held stable. `ser_done` is ignored in the first WAIT cycle (the one where `ser_valid` is high). Any later `ser_done`=1 returns the FSM to IDLE.
- No word is ever lost or duplicated; words are launched in FIFO order.
- `ser_data` keeps its last value in IDLE (it is not cleared after done).
- Reset mid-operation: everything returns to reset values immediately.
  - FIFO contents are discarded and `ser_valid` deasserts asynchronously.

## Timing
- Push-to-launch latency: a word written at edge t into an empty FIFO with the FSM in IDLE gives `ser_valid`=1 and `ser_data`=word after edge t+1 (one cycle).
- Done-to-next-launch: `ser_done` sampled at edge d moves the FSM to IDLE. If `count>0`, the next `ser_valid` follows edge d+1.
- Minimum spacing between `ser_valid` pulses: 3 cycles (launch, ≥1 WAIT cycle, IDLE).
- The serializer updates on negedge. `ser_valid` and `ser_data` are posedge-registered, so they are stable across the following negedge.
- `count` reflects the pop in the same edge that raises `ser_valid`.

## Configuration
- `PISO_FEEDER_TIMEOUT_EN` defined:
  - A counter runs in WAIT, clearing on entry.
  - If TIMEOUT cycles elapse without `ser_done`, `err_timeout` is set and stays high until reset, and the FSM returns to IDLE.
  - The in-flight word is dropped; the next FIFO word may launch.
- Macro undefined:
  - No counter; WAIT holds indefinitely until `ser_done`.
  - `err_timeout` is constant 0.

## Test plan
- Reset, then push 0x55 with the FIFO empty:
  - `ser_valid` pulses 1 cycle after the push with `ser_data`=0x55, and `busy`=1.
  - With `ser_done` 8 cycles later, the FSM returns to IDLE and `count`=0.
- Fill path: push 5 words back-to-back with `ser_done` held 0 (DEPTH=4):
  - The first word launches.
  - `in_ready` drops once `count`=4, and the 5th word is held until a done frees space.
  - The output order matches the input order.
- `ser_done` pulse while IDLE, and in the same cycle as `ser_valid`:
  - Both are ignored, with no state change and no extra launch.
- Continuous stream with `ser_done` exactly N+1 cycles after each `ser_valid`:
  - `ser_valid` pulses are spaced N+3 cycles.
  - There are no drops, and pointer wrap-around is exercised over 3×DEPTH words.
- Assert `rst_n` low during WAIT with `count`=2:
  - All outputs read their reset values within the same cycle.
  - After release, no stale word is launched.
- With `PISO_FEEDER_TIMEOUT_EN` and TIMEOUT=16, never assert `ser_done`:
  - `err_timeout` rises after 16 WAIT cycles and stays high.
  - The next queued word launches on the following cycle.

Source files
------------

// File: rtl/piso_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | piso_feeder                                                                |
// | FIFO-buffered launcher of N-bit codewords into a parallel-to-serial        |
// | serializer. Optional WAIT timeout enabled by PISO_FEEDER_TIMEOUT_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module piso_feeder #(
  parameter int N       = 7,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N-1:0]           in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N-1:0]           ser_data,
  output logic                   ser_valid,
  input  logic                   ser_done,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err_timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_full = CW'(DEPTH);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [N-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [0:0]    r_state;

  logic w_push;
  logic w_pop;
  logic w_done;
  logic w_timeout;
  logic w_leave;

  assign in_ready = rst_n && (r_count != c_full);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = (r_state == S_IDLE) && (r_count != '0);
  // ser_valid is high exactly in the first WAIT cycle, so it masks ser_done there
  assign w_done   = (r_state == S_WAIT) && !ser_valid && ser_done;
  assign w_leave  = w_done || w_timeout;

  assign busy  = (r_state == S_WAIT);
  assign count = r_count;

`ifdef PISO_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] c_tmo_last = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_tmo_cnt;
  logic          r_err_timeout;

  // A done arriving on the expiry cycle wins over the timeout
  assign w_timeout   = (r_state == S_WAIT) && (r_tmo_cnt == c_tmo_last) && !w_done;
  assign err_timeout = r_err_timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo_cnt     <= '0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_pop) begin
        r_tmo_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_timeout   = 1'b0;
  assign err_timeout = 1'b0;
`endif

  // Storage is not reset; occupancy and pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_state   <= S_IDLE;
      ser_data  <= '0;
      ser_valid <= 1'b0;
    end else begin
      ser_valid <= w_pop;

      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
        ser_data <= r_mem[r_rd_ptr];
      end

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (w_leave) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_feeder.sv
`default_nettype none
// Directed self-checking bench for piso_feeder (N=7, DEPTH=4, TIMEOUT=16).
module tb_piso_feeder;

  localparam int N       = 7;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 16;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] ser_data;
  logic         ser_valid;
  logic         ser_done;
  logic         busy;
  logic [2:0]   count;
  logic         err_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  piso_feeder #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .ser_data    (ser_data),
    .ser_valid   (ser_valid),
    .ser_done    (ser_done),
    .busy        (busy),
    .count       (count),
    .err_timeout (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] stream_word(int i);
    return N'((i * 37 + 3) % 128);
  endfunction

  task automatic test_reset();
    rst_n    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    ser_done = 1'b0;
    step();
    step();
    n_checks++;
    if ({ser_valid, busy, err_timeout, in_ready} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: got valid/busy/err/ready=%b expected 0000",
               {ser_valid, busy, err_timeout, in_ready});
    end
    n_checks++;
    if (ser_data !== 7'h00 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_data_count: got data=%h count=%0d expected 00/0", ser_data, count);
    end
    rst_n = 1'b1;
    step();
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single();
    in_data  = 7'h55;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd1 || ser_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_push: got count=%0d valid=%b expected 1/0", count, ser_valid);
    end
    step();
    n_checks++;
    if (ser_valid !== 1'b1 || ser_data !== 7'h55 || busy !== 1'b1 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_launch: got valid=%b data=%h busy=%b count=%0d expected 1/55/1/0",
               ser_valid, ser_data, busy, count);
    end
    step();
    n_checks++;
    if (ser_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_pulse_width: got valid=%b busy=%b expected 0/1", ser_valid, busy);
    end
    for (int i = 0; i < 5; i++) step();
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || count !== 3'd0 || ser_data !== 7'h55) begin
      n_fail++;
      $display("FAIL single_done: got busy=%b count=%0d data=%h expected 0/0/55",
               busy, count, ser_data);
    end
  endtask

  task automatic test_ignored_done();
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || ser_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL idle_done: got busy=%b valid=%b count=%0d expected 0/0/0",
               busy, ser_valid, count);
    end
    in_data  = 7'h2A;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n_checks++;
    if (ser_valid !== 1'b1 || ser_data !== 7'h2A) begin
      n_fail++;
      $display("FAIL ign_launch: got valid=%b data=%h expected 1/2a", ser_valid, ser_data);
    end
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || ser_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL first_wait_done: got busy=%b valid=%b expected 1/0", busy, ser_valid);
    end
    step();
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    step();
    n_checks++;
    if (busy !== 1'b0 || ser_valid !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL ign_no_extra: got busy=%b valid=%b count=%0d expected 0/0/0",
               busy, ser_valid, count);
    end
  endtask

  task automatic test_fill();
    logic [N-1:0] words [6];
    words[0] = 7'h11; words[1] = 7'h22; words[2] = 7'h33;
    words[3] = 7'h44; words[4] = 7'h55; words[5] = 7'h66;
    in_valid = 1'b1;
    in_data  = words[0];
    step();
    in_data  = words[1];
    step();
    n_checks++;
    if (ser_valid !== 1'b1 || ser_data !== words[0] || count !== 3'd1) begin
      n_fail++;
      $display("FAIL fill_first: got valid=%b data=%h count=%0d expected 1/11/1",
               ser_valid, ser_data, count);
    end
    for (int i = 2; i < 5; i++) begin
      in_data = words[i];
      step();
    end
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_full: got count=%0d ready=%b expected 4/0", count, in_ready);
    end
    in_data = words[5];
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_hold: got count=%0d ready=%b expected 4/0", count, in_ready);
    end
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || count !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_refuse_on_pop: got busy=%b count=%0d expected 0/4", busy, count);
    end
    step();
    n_checks++;
    if (ser_valid !== 1'b1 || ser_data !== words[1] || count !== 3'd3 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_second: got valid=%b data=%h count=%0d ready=%b expected 1/22/3/1",
               ser_valid, ser_data, count, in_ready);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (count !== 3'd4) begin
      n_fail++;
      $display("FAIL fill_sixth_in: got count=%0d expected 4", count);
    end
    for (int i = 2; i < 6; i++) begin
      step();
      ser_done = 1'b1;
      step();
      ser_done = 1'b0;
      step();
      n_checks++;
      if (ser_valid !== 1'b1 || ser_data !== words[i]) begin
        n_fail++;
        $display("FAIL fill_order[%0d]: got valid=%b data=%h expected 1/%h",
                 i, ser_valid, ser_data, words[i]);
      end
    end
    step();
    ser_done = 1'b1;
    step();
    ser_done = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL fill_drained: got busy=%b count=%0d expected 0/0", busy, count);
    end
  endtask

  task automatic test_stream();
    int cyc   = 0;
    int k     = 0;
    int vcyc  = -100;
    fork
      begin
        for (int i = 0; i < 3 * DEPTH; i++) begin
          int guard = 0;
          in_data  = stream_word(i);
          in_valid = 1'b1;
          while (!in_ready && guard < 300) begin
            step();
            guard++;
          end
          step();
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 0; c < 400; c++) begin
          step();
          ser_done = 1'b0;
          cyc++;
          if (k == 3 * DEPTH && cyc == vcyc + 9) break;
          if (ser_valid) begin
            n_checks++;
            if (ser_data !== stream_word(k)) begin
              n_fail++;
              $display("FAIL stream_data[%0d]: got %h expected %h", k, ser_data, stream_word(k));
            end
            if (k > 0) begin
              n_checks++;
              if (cyc - vcyc != N + 3) begin
                n_fail++;
                $display("FAIL stream_spacing[%0d]: got %0d expected %0d", k, cyc - vcyc, N + 3);
              end
            end
            vcyc = cyc;
            k++;
          end
          if (cyc == vcyc + N + 1) ser_done = 1'b1;
        end
        ser_done = 1'b0;
      end
    join
    n_checks++;
    if (k != 3 * DEPTH) begin
      n_fail++;
      $display("FAIL stream_count: got %0d launches expected %0d", k, 3 * DEPTH);
    end
    n_checks++;
    if (busy !== 1'b0 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL stream_end: got busy=%b count=%0d expected 0/0", busy, count);
    end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_data  = 7'h01;
    step();
    in_data  = 7'h02;
    step();
    in_data  = 7'h03;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || count !== 3'd2) begin
      n_fail++;
      $display("FAIL mid_setup: got busy=%b count=%0d expected 1/2", busy, count);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ser_valid, busy, err_timeout, in_ready} !== 4'b0000 ||
        ser_data !== 7'h00 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL mid_async: got v/b/e/r=%b data=%h count=%0d expected 0000/00/0",
               {ser_valid, busy, err_timeout, in_ready}, ser_data, count);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      n_checks++;
      if (ser_valid !== 1'b0 || count !== 3'd0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_stale[%0d]: got valid=%b count=%0d busy=%b expected 0/0/0",
                 i, ser_valid, count, busy);
      end
    end
  endtask

`ifdef PISO_FEEDER_TIMEOUT_EN
  task automatic test_timeout();
    in_valid = 1'b1;
    in_data  = 7'h3C;
    step();
    in_data  = 7'h4D;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    n_checks++;
    if (err_timeout !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_early: got err=%b busy=%b expected 0/1", err_timeout, busy);
    end
    step();
    n_checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_fire: got err=%b busy=%b expected 1/0", err_timeout, busy);
    end
    step();
    n_checks++;
    if (ser_valid !== 1'b1 || ser_data !== 7'h4D) begin
      n_fail++;
      $display("FAIL tmo_next: got valid=%b data=%h expected 1/4d", ser_valid, ser_data);
    end
    ser_done = 1'b1;
    step();
    step();
    ser_done = 1'b0;
    n_checks++;
    if (err_timeout !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_sticky: got err=%b busy=%b expected 1/0", err_timeout, busy);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_ignored_done();
    test_fill();
    test_stream();
    test_reset_mid();
`ifdef PISO_FEEDER_TIMEOUT_EN
    test_timeout();
`else
    n_checks++;
    if (err_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL err_tied: got %b expected 0", err_timeout);
    end
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
